// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, forward-select codes and the writeback tag type
package mips_pkg;
  localparam int REG_AW = 5;
  localparam int DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_WB = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_EX = 2'd3;
  typedef struct packed {
    logic valid;
    logic [REG_AW-1:0] waddr;
    logic is_load;
  } wb_tag_t;
  function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel, input logic [DW-1:0] rf, wb, mem, ex);
    return sel == FWD_EX ? ex : sel == FWD_MEM ? mem : sel == FWD_WB ? wb : rf;
  endfunction
endpackage

// File: rtl/fwd_sel_logic.sv
// fwd_sel_logic: newest-writer forward select for one source operand
// Ports: raddr source register; ex/mem/wb in-flight tags;
//        sel forward source code; load_hit EX holds a load to raddr.
module fwd_sel_logic
  import mips_pkg::*;
(
  input  logic [REG_AW-1:0] raddr,
  input  wb_tag_t           ex,
  input  wb_tag_t           mem,
  input  wb_tag_t           wb,
  output logic [1:0]        sel,
  output logic              load_hit
);
  logic unused;
  assign unused = &{1'b0, mem.is_load, wb.is_load};
  // A load in EX has no data yet, so it is never a forward source; it only
  // raises load_hit and the select falls through to older stages.
  always_comb begin
    load_hit = ex.valid && ex.is_load && ex.waddr == raddr;
    sel = raddr == REG_ZERO ? FWD_RF :
          (ex.valid && !ex.is_load && ex.waddr == raddr) ? FWD_EX :
          (mem.valid && mem.waddr == raddr) ? FWD_MEM :
          (wb.valid && wb.waddr == raddr) ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/wb_forward_ctrl.sv
// wb_forward_ctrl: in-flight write tracking, operand forwarding, load-use stall, regfile write port
// Ports: id_* decode-stage instruction; flush squashes ID and EX;
//        rf_rdata*/ex_result/mem_result/wb_result candidate operand values;
//        opnd*/fwd_sel* forwarded operands and their source; stall load-use hold;
//        rf_we/rf_waddr/rf_wdata register file write port driven from WB.
module wb_forward_ctrl
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_raddr1,
  input  logic [REG_AW-1:0] id_raddr2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_we,
  input  logic [REG_AW-1:0] id_waddr,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic [DW-1:0]     rf_rdata1,
  input  logic [DW-1:0]     rf_rdata2,
  input  logic [DW-1:0]     ex_result,
  input  logic [DW-1:0]     mem_result,
  input  logic [DW-1:0]     wb_result,
  output logic [DW-1:0]     opnd1,
  output logic [DW-1:0]     opnd2,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic              stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DW-1:0]     rf_wdata
);
  wb_tag_t id_tag, ex_tag, mem_tag, wb_tag;
  logic hit1, hit2;
  fwd_sel_logic u_sel1 (.raddr(id_raddr1), .ex(ex_tag), .mem(mem_tag), .wb(wb_tag), .sel(fwd_sel1), .load_hit(hit1));
  fwd_sel_logic u_sel2 (.raddr(id_raddr2), .ex(ex_tag), .mem(mem_tag), .wb(wb_tag), .sel(fwd_sel2), .load_hit(hit2));
  // Untracked instructions enter as an all-zero bubble so rf_waddr stays 0 for them.
  always_comb begin
    id_tag = (id_valid && id_we && id_waddr != REG_ZERO) ? wb_tag_t'{1'b1, id_waddr, id_is_load} : wb_tag_t'('0);
    stall = id_valid && ((id_use1 && hit1) || (id_use2 && hit2));
    opnd1 = fwd_mux(fwd_sel1, rf_rdata1, wb_result, mem_result, ex_result);
    opnd2 = fwd_mux(fwd_sel2, rf_rdata2, wb_result, mem_result, ex_result);
    rf_we = wb_tag.valid;
    rf_waddr = wb_tag.waddr;
    rf_wdata = wb_result;
  end
  // Flush kills the ID and EX instructions; a stall only holds ID back.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_tag <= '0;
      mem_tag <= '0;
      wb_tag <= '0;
    end else begin
      ex_tag <= (flush || stall) ? wb_tag_t'('0) : id_tag;
      mem_tag <= flush ? wb_tag_t'('0) : ex_tag;
      wb_tag <= mem_tag;
    end
endmodule

// File: tb/tb_wb_forward_ctrl.sv
// tb_wb_forward_ctrl: directed vector table, reset corner cases and randomized model checks
module tb_wb_forward_ctrl;
  logic clk = 0, rst_n = 0;
  logic id_valid = 0, id_use1 = 0, id_use2 = 0, id_we = 0, id_is_load = 0, flush = 0;
  logic [4:0] id_raddr1 = 0, id_raddr2 = 0, id_waddr = 0;
  logic [31:0] rf_rdata1 = 32'hAAAA0001, rf_rdata2 = 32'hBBBB0002;
  logic [31:0] ex_result = 32'h11, mem_result = 32'hDEAD, wb_result = 32'h33;
  logic [31:0] opnd1, opnd2, rf_wdata;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic stall, rf_we;
  logic [4:0] rf_waddr;
  int n_chk = 0, n_fail = 0;

  localparam logic [31:0] RF1 = 32'hAAAA0001, RF2 = 32'hBBBB0002, D = 32'hDEAD, W = 32'h33;

  wb_forward_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_use1(id_use1), .id_use2(id_use2), .id_we(id_we), .id_waddr(id_waddr), .id_is_load(id_is_load),
    .flush(flush), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_result(ex_result),
    .mem_result(mem_result), .wb_result(wb_result), .opnd1(opnd1), .opnd2(opnd2),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall(stall), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, r_u1, r_u2, we, ld, fl;
    logic [4:0] r1, r2, wa;
    logic [31:0] mem, wb;
    logic [1:0] s1, s2;
    logic st, rwe;
    logic [4:0] rwa;
    logic [31:0] o1, o2;
  } vec_t;

  // Reference model: last three issue slots, newest first (0=EX, 1=MEM, 2=WB).
  typedef struct { bit w; bit [4:0] a; bit ld; } slot_t;
  slot_t hist[3];

  function automatic vec_t mk(input logic v, input logic [4:0] r1, r2, input logic u1, u2, we,
                              input logic [4:0] wa, input logic ld, fl, input logic [31:0] mem, wb,
                              input logic [1:0] s1, s2, input logic st, rwe, input logic [4:0] rwa,
                              input logic [31:0] o1, o2);
    vec_t t;
    t.v = v; t.r1 = r1; t.r2 = r2; t.r_u1 = u1; t.r_u2 = u2; t.we = we; t.wa = wa; t.ld = ld; t.fl = fl;
    t.mem = mem; t.wb = wb; t.s1 = s1; t.s2 = s2; t.st = st; t.rwe = rwe; t.rwa = rwa; t.o1 = o1; t.o2 = o2;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, r2, input logic u1, u2, we,
                       input logic [4:0] wa, input logic ld, fl);
    id_valid = v; id_raddr1 = r1; id_raddr2 = r2; id_use1 = u1; id_use2 = u2;
    id_we = we; id_waddr = wa; id_is_load = ld; flush = fl;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s1, s2, input logic st, rwe,
                         input logic [4:0] rwa, input logic [31:0] o1, o2);
    chk({tag, " fwd_sel1"}, 32'(fwd_sel1), 32'(s1));
    chk({tag, " fwd_sel2"}, 32'(fwd_sel2), 32'(s2));
    chk({tag, " stall"}, 32'(stall), 32'(st));
    chk({tag, " rf_we"}, 32'(rf_we), 32'(rwe));
    chk({tag, " rf_waddr"}, 32'(rf_waddr), 32'(rwa));
    chk({tag, " opnd1"}, opnd1, o1);
    chk({tag, " opnd2"}, opnd2, o2);
    chk({tag, " rf_wdata"}, rf_wdata, wb_result);
  endtask

  function automatic logic [1:0] m_sel(input logic [4:0] ra);
    logic [1:0] s = 0;
    bit found = 0;
    if (ra != 0)
      for (int i = 0; i < 3; i++)
        if (!found && hist[i].w && hist[i].a == ra && !(i == 0 && hist[i].ld)) begin
          s = 2'(3 - i);
          found = 1;
        end
    return s;
  endfunction

  function automatic logic [31:0] m_val(input logic [1:0] s, input logic [31:0] rf);
    return s == 3 ? ex_result : s == 2 ? mem_result : s == 1 ? wb_result : rf;
  endfunction

  vec_t tbl[23];

  initial begin
    logic [1:0] e1, e2;
    logic est;
    slot_t nw;
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[1]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0, D, W, 3, 0, 0, 0, 0, 32'h11, RF2);
    tbl[2]  = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[3]  = mk(1, 3, 5, 0, 1, 0, 0, 0, 0, D, W, 1, 0, 1, 1, 3, W, RF2);
    tbl[4]  = mk(1, 3, 5, 0, 1, 0, 0, 0, 0, D, W, 0, 2, 0, 0, 0, RF1, D);
    tbl[5]  = mk(1, 0, 0, 0, 0, 1, 7, 0, 0, D, W, 0, 0, 0, 1, 5, RF1, RF2);
    tbl[6]  = mk(1, 7, 0, 1, 0, 1, 7, 0, 0, D, W, 3, 0, 0, 0, 0, 32'h11, RF2);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[8]  = mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 1, 7, 2, RF2);
    tbl[9]  = mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 5, 2, 1, 0, 0, 1, 7, 2, RF2);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[11] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[14] = mk(1, 0, 0, 0, 0, 1, 9, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[15] = mk(0, 9, 0, 1, 0, 0, 0, 0, 1, D, W, 3, 0, 0, 0, 0, 32'h11, RF2);
    tbl[16] = mk(1, 9, 0, 1, 0, 0, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[19] = mk(1, 0, 0, 0, 0, 1, 4, 1, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[20] = mk(1, 4, 0, 1, 0, 0, 0, 0, 1, D, W, 0, 0, 1, 0, 0, RF1, RF2);
    tbl[21] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, D, W, 0, 0, 0, 0, 0, RF1, RF2);

    repeat (2) @(negedge clk);
    #1 chk_all("reset", 0, 0, 0, 0, 0, RF1, RF2);
    @(negedge clk) rst_n = 1;

    for (int i = 0; i < 23; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].v, tbl[i].r1, tbl[i].r2, tbl[i].r_u1, tbl[i].r_u2, tbl[i].we, tbl[i].wa, tbl[i].ld, tbl[i].fl);
      mem_result = tbl[i].mem; wb_result = tbl[i].wb;
      #1 chk_all($sformatf("row%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].st, tbl[i].rwe, tbl[i].rwa, tbl[i].o1, tbl[i].o2);
    end

    // Async reset while a load-use stall is active and WB holds a write.
    mem_result = D; wb_result = W;
    @(negedge clk) drive(1, 0, 0, 0, 0, 1, 2, 0, 0);
    @(negedge clk) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) drive(1, 0, 0, 0, 0, 1, 6, 1, 0);
    @(negedge clk) drive(1, 6, 2, 1, 0, 0, 0, 0, 0);
    #1 chk_all("pre_rst", 0, 1, 1, 1, 2, RF1, W);
    #2 rst_n = 0;
    #1 chk_all("mid_rst", 0, 0, 0, 0, 0, RF1, RF2);
    @(negedge clk) #1 chk_all("in_rst", 0, 0, 0, 0, 0, RF1, RF2);
    rst_n = 1;
    @(negedge clk) #1 chk_all("post_rst", 0, 0, 0, 0, 0, RF1, RF2);

    // Randomized run against the slot-history model.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0};
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
      rf_rdata1 = $urandom; rf_rdata2 = $urandom; ex_result = $urandom;
      mem_result = $urandom; wb_result = $urandom;
      e1 = m_sel(id_raddr1);
      e2 = m_sel(id_raddr2);
      est = id_valid && hist[0].w && hist[0].ld &&
            ((id_use1 && id_raddr1 == hist[0].a) || (id_use2 && id_raddr2 == hist[0].a));
      #1 chk_all($sformatf("rand%0d", c), e1, e2, est, hist[2].w, hist[2].a,
                 m_val(e1, rf_rdata1), m_val(e2, rf_rdata2));
      nw = (flush || est || !(id_valid && id_we && id_waddr != 0)) ? '{0, 0, 0} : '{1, id_waddr, id_is_load};
      hist[2] = hist[1];
      hist[1] = flush ? '{0, 0, 0} : hist[0];
      hist[0] = nw;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_forward_ctrl.md
# wb_forward_ctrl

Writer-side companion to the 32x32 register file. Tracks in-flight register writes through EX/MEM/WB and drives the register file write port from the WB stage. Forwards the newest in-flight value to the ID-stage operands and raises a load-use stall. Sits between the decode stage, the register file read/write ports and the EX/MEM/WB datapath.

## Interface
- No parameters; widths fixed: `REG_AW=5` and `DW=32`, both from the shared package.
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — one clock; reset is asynchronous and active-low.
- `id_valid` in 1 — ID holds a real instruction.
- `id_raddr1`, `id_raddr2` in 5 — source register addresses, also driven to the regfile read ports.
- `id_use1`, `id_use2` in 1 — the instruction actually reads that source.
- `id_we` in 1 — the instruction writes a register.
- `id_waddr` in 5 — destination register.
- `id_is_load` in 1 — the destination value comes from memory.
- `flush` in 1 — squash the instructions in ID and EX (branch/jump redirect).
- `rf_rdata1`, `rf_rdata2` in 32 — register file read data.
- `ex_result` in 32 — ALU result of the EX-stage instruction.
- `mem_result` in 32 — final MEM-stage value; load data is valid here.
- `wb_result` in 32 — WB-stage value.
- `opnd1`, `opnd2` out 32 — forwarded operands.
- `fwd_sel1`, `fwd_sel2` out 2 — source select: 0 RF, 1 WB, 2 MEM, 3 EX.
- `stall` out 1 — hold PC and ID; insert a bubble into EX.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32 — register file write port.

## Operation
- Three tag registers: EX, MEM, WB. Each holds `{valid, waddr[4:0], is_load}`.
- A tag is valid only when `id_valid && id_we && id_waddr!=0`. Writes to $zero are never tracked.
- Advance on every clock edge, evaluated in this priority:
  - `flush`: EX←bubble, MEM←bubble, WB←MEM. Flush overrides stall.
  - `stall`: EX←bubble, MEM←EX, WB←MEM.
  - otherwise: EX←ID tag, MEM←EX, WB←MEM.
- Load-use stall (combinational):
  - `stall = id_valid && ex.valid && ex.is_load && ((id_use1 && id_raddr1==ex.waddr) || (id_use2 && id_raddr2==ex.waddr))`.
  - A load in MEM never stalls.
- Forward select per operand n, first match wins:
  - address 0 → RF.
  - EX valid, not load, waddr match → EX.
  - MEM valid, waddr match → MEM.
  - WB valid, waddr match → WB.
  - otherwise → RF.
- While `stall` is high, the EX-load match must not select EX. The select falls through to MEM/WB/RF; the operand value is don't-care, because ID re-evaluates next cycle.
- `opnd` muxes on `fwd_sel`. The `id_use` bits affect only the stall, not the forwarding.
- Write port: `rf_we=wb.valid`, `rf_waddr=wb.waddr`, `rf_wdata=wb_result`.

## Timing
- Operands, selects and stall are combinational from inputs and tags, within the same cycle.
- Tags advance one stage per cycle. An ID write reaches `rf_we` 3 edges after issue, unless killed by flush.
- Load-use costs exactly 1 bubble. In the next cycle the load is in MEM and is forwarded from `mem_result`.
- WB forwarding covers the regfile write-then-read window: the regfile is written at the WB edge, and the read is combinational.
- Reset (asynchronous, any cycle including mid-stall): all tags are cleared. During and after reset: `stall=0`, `rf_we=0`, `rf_waddr=0`, `fwd_sel*=0`, `opnd*=rf_rdata*`. The first valid tag can appear in EX on the first edge after `rst_n` rises.
- `flush` and `stall` in the same cycle: flush wins and no bubble is double-counted. The next cycle has EX and MEM empty.

## Structure
- Shared package `mips_pkg` holds:
  - `REG_AW`, `DW`, `REG_ZERO=5'd0`;
  - `FWD_RF/FWD_WB/FWD_MEM/FWD_EX` constants;
  - the `wb_tag_t` struct `{valid, waddr, is_load}`.
- One sub-module, `fwd_sel_logic`, instantiated twice. Its inputs are one source address and the three tags; its outputs are the 2-bit select plus a load-hit flag for the stall OR.
- The tag pipeline and write-port drive live in the top module.

## Test plan
- ALU back-to-back: ID issues `r3=` with `ex_result=0x11`, then the next instruction reads r3. Required: `fwd_sel1=3`, `opnd1=0x11`, `stall=0`.
- Load-use: EX holds a load to r5, ID reads r5 (`id_use2=1`). Required: `stall=1` for exactly 1 cycle. Next cycle: `fwd_sel2=2`, `opnd2=mem_result=0xDEAD`.
- Priority: r7 is pending in both WB (`wb_result=1`) and MEM (`mem_result=2`). Required: `opnd1=2`. After one more cycle with no new r7 writer: `fwd_sel1=1`, `opnd1=2`. Then `rf_we=1`, `rf_waddr=7`.
- $zero: issue a write to r0, then a read of r0. Required: no tag allocated, `fwd_sel=0`, `rf_we` stays 0 three cycles later.
- Flush: a write to r9 in EX with `flush=1`. Required: r9 never appears on `rf_waddr`, and a subsequent r9 read selects RF.
- Async reset mid-stall: drop `rst_n` while `stall=1`. Required: immediately `stall=0` and `rf_we=0`, and all selects are 0 until new issues.
